// File: rtl/db_multi_pkg.sv
// Shared defaults and width helper for the multi-channel debouncer and its bench.
package db_multi_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_TICK_DIV     = 50_000;  // 1 ms tick at 50 MHz
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_LONG_TICKS   = 1000;

    // Width of a counter that must hold the values 0..n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/db_chan.sv
// One debounce channel: 2-FF synchroniser, tick-based stability filter,
// edge pulses and optional long-press detection.
module db_chan
    import db_multi_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic inv,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic long_held
);

    localparam int CW = cnt_width(STABLE_TICKS);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          s;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          rise_reg;
    logic          fall_reg;
    logic          accept;

    assign s      = sync2_reg ^ inv;
    assign accept = (s != level_reg) && tick && (cnt_reg == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (s == level_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (accept) begin
                    level_reg <= s;
                    cnt_reg   <= '0;
                    rise_reg  <= s;
                    fall_reg  <= ~s;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

    generate
        if (LONG_TICKS > 0) begin : g_long
            localparam int HW = cnt_width(LONG_TICKS);

            logic [HW-1:0] hcnt_reg;
            logic          lp_reg;
            logic          held_reg;

            // accept while pressed is the release edge: drop long_held with fall
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt_reg <= '0;
                    lp_reg   <= 1'b0;
                    held_reg <= 1'b0;
                end else begin
                    lp_reg <= 1'b0;
                    if (!level_reg || accept) begin
                        hcnt_reg <= '0;
                        held_reg <= 1'b0;
                    end else if (tick && (hcnt_reg < HW'(LONG_TICKS))) begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                        if (hcnt_reg == HW'(LONG_TICKS - 1)) begin
                            lp_reg   <= 1'b1;
                            held_reg <= 1'b1;
                        end
                    end
                end
            end

            assign long_press = lp_reg;
            assign long_held  = held_reg;
        end else begin : g_no_long
            assign long_press = 1'b0;
            assign long_held  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/db_multi.sv
// N-channel pushbutton debouncer: one shared tick prescaler feeding
// independent per-channel filters.
module db_multi
    import db_multi_pkg::*;
#(
    parameter int                  CHANNELS     = DEF_CHANNELS,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW   = '0,
    parameter int                  TICK_DIV     = DEF_TICK_DIV,
    parameter int                  STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int                  LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] long_held
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pre_cnt_reg;
    logic          tick;

    assign tick = (pre_cnt_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            db_chan #(
                .STABLE_TICKS (STABLE_TICKS),
                .LONG_TICKS   (LONG_TICKS)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw        (in_raw[gi]),
                .inv        (ACTIVE_LOW[gi]),
                .tick       (tick),
                .level      (level[gi]),
                .rise       (rise[gi]),
                .fall       (fall[gi]),
                .long_press (long_press[gi]),
                .long_held  (long_held[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_db_multi.sv
// Directed bench for db_multi: reset, bounce rejection, release, long/short press,
// channel independence and reset during a long-press count.
module tb_db_multi;
    import db_multi_pkg::*;

    localparam int CH = 2;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] in_raw;
    logic [CH-1:0] level, rise, fall, long_press, long_held;

    db_multi #(
        .CHANNELS     (CH),
        .ACTIVE_LOW   (2'b10),
        .TICK_DIV     (10),
        .STABLE_TICKS (4),
        .LONG_TICKS   (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_raw     (in_raw),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .long_held  (long_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters and edge-consistency monitor, sampled mid-cycle
    int rise_cnt [CH];
    int fall_cnt [CH];
    int lp_cnt   [CH];
    int bad_edge = 0;
    logic [CH-1:0] lvl_prev = '0;

    initial begin
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            lp_cnt[i]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst_n) begin
                rise_cnt[i] += int'(rise[i]);
                fall_cnt[i] += int'(fall[i]);
                lp_cnt[i]   += int'(long_press[i]);
                if (rise[i] !== (level[i] & ~lvl_prev[i]) ||
                    fall[i] !== (~level[i] & lvl_prev[i]))
                    bad_edge++;
            end else begin
                rise_cnt[i] += int'(rise[i]);
                lp_cnt[i]   += int'(long_press[i]);
            end
        end
        lvl_prev = rst_n ? level : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = rise, 1 = fall, 2 = long_press; cycles = -1 on timeout
    task automatic wait_sig(input int which, input int ch, input int max, output int cycles);
        logic hit;
        cycles = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            case (which)
                0:       hit = rise[ch];
                1:       hit = fall[ch];
                default: hit = long_press[ch];
            endcase
            if (hit) begin
                cycles = k;
                break;
            end
        end
    endtask

    int cyc;
    int r0, f0, l0, r1;
    logic seen_level;
    logic held_prev;

    initial begin
        // 1. reset with both pins high; ch1 is active-low so it reads released
        rst_n  = 1'b0;
        in_raw = 2'b11;
        repeat (5) step();
        check("rst_level", 32'(level), 0);
        check("rst_pulses", 32'({rise, fall, long_press, long_held}), 0);
        rst_n = 1'b1;
        wait_sig(0, 0, 100, cyc);
        check("rst_rise_lat_ok", 32'(cyc >= 33 && cyc <= 42), 1);
        check("rst_ch1_level", 32'(level[1]), 0);
        step();
        check("rst_rise_width", 32'(rise[0]), 0);
        check("rst_ch1_rise_cnt", 32'(rise_cnt[1]), 0);

        // 3. release ch0
        r0 = rise_cnt[0];
        f0 = fall_cnt[0];
        in_raw[0] = 1'b0;
        repeat (100) step();
        check("rel_fall_cnt", 32'(fall_cnt[0] - f0), 1);
        check("rel_level", 32'(level[0]), 0);
        check("rel_no_rise", 32'(rise_cnt[0] - r0), 0);

        // 2. bounce: 15-cycle segments never survive 4 ticks
        r0 = rise_cnt[0];
        seen_level = 1'b0;
        for (int t = 0; t < 20; t++) begin
            in_raw[0] = ~in_raw[0];
            repeat (15) begin
                step();
                seen_level |= level[0];
            end
        end
        check("bnc_no_level", 32'(seen_level), 0);
        check("bnc_no_rise", 32'(rise_cnt[0] - r0), 0);
        in_raw[0] = 1'b1;
        wait_sig(0, 0, 60, cyc);
        check("bnc_rise_lat_ok", 32'(cyc >= 31 && cyc <= 42), 1);

        // 4. long press: 20 ticks after rise
        l0 = lp_cnt[0];
        wait_sig(2, 0, 300, cyc);
        check("lp_lat_ok", 32'(cyc >= 190 && cyc <= 210), 1);
        check("lp_held_set", 32'(long_held[0]), 1);
        repeat (100) step();
        check("lp_once", 32'(lp_cnt[0] - l0), 1);
        check("lp_held_stays", 32'(long_held[0]), 1);
        in_raw[0] = 1'b0;
        held_prev = long_held[0];
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            held_prev = long_held[0];
            step();
            if (fall[0]) begin
                cyc = k;
                break;
            end
        end
        check("lp_fall_seen", 32'(cyc > 0), 1);
        check("lp_held_before_fall", 32'(held_prev), 1);
        check("lp_held_clr_at_fall", 32'(long_held[0]), 0);
        repeat (50) step();

        // 5. short press
        r0 = rise_cnt[0];
        f0 = fall_cnt[0];
        l0 = lp_cnt[0];
        in_raw[0] = 1'b1;
        repeat (100) step();
        in_raw[0] = 1'b0;
        repeat (100) step();
        check("sp_rise", 32'(rise_cnt[0] - r0), 1);
        check("sp_fall", 32'(fall_cnt[0] - f0), 1);
        check("sp_no_long", 32'(lp_cnt[0] - l0), 0);
        check("sp_no_held", 32'(long_held[0]), 0);

        // 6. both channels pressed together, then reset mid long count
        in_raw = 2'b01;
        wait_sig(0, 0, 60, cyc);
        check("ind_rise0_seen", 32'(cyc > 0), 1);
        check("ind_rise1_same", 32'(rise[1]), 1);
        check("ind_levels", 32'(level), 32'h3);
        repeat (100) step();
        r0 = rise_cnt[0];
        r1 = rise_cnt[1];
        l0 = lp_cnt[0] + lp_cnt[1];
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({level, rise, fall, long_press, long_held}), 0);
        repeat (3) step();
        in_raw = 2'b10;
        rst_n  = 1'b1;
        repeat (250) step();
        check("mid_rst_no_rise", 32'((rise_cnt[0] - r0) + (rise_cnt[1] - r1)), 0);
        check("mid_rst_no_long", 32'(lp_cnt[0] + lp_cnt[1] - l0), 0);
        check("mid_rst_level", 32'({level, long_held}), 0);

        check("edge_consistency", 32'(bad_edge), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
